dmfb_train_move_sequencer: RTL and testbench

DMFB_TRAIN_MOVE_SEQUENCER -- requirements
Module: dmfb_train_move_sequencer

---
 rtl/dmfb_train_move_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_dmfb_train_move_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmfb_train_move_sequencer.sv
// dmfb_train_move_sequencer
// Moves a train of TRAIN_LEN electrodes one position at a time from a start
// head position to a destination.  Each step actuates the train for HOLD_CYC
// cycles, then leaves it idle for GAP_CYC cycles, then advances the head.
// Final head positions are stored per droplet so that a later move can start
// from where the droplet was left.

module dmfb_train_move_sequencer #(
    parameter  int ADDR_W    = 4,
    parameter  int TRAIN_LEN = 4,
    parameter  int NUM_DROP  = 2,
    parameter  int HOLD_CYC  = 1000,
    parameter  int GAP_CYC   = 100,
    localparam int DROP_W    = (NUM_DROP > 1) ? $clog2(NUM_DROP) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          start,
    input  logic [DROP_W-1:0]             drop_sel,
    input  logic                          use_stored,
    input  logic [ADDR_W-1:0]             src,
    input  logic [ADDR_W-1:0]             dest,
    output logic                          act,
    output logic [TRAIN_LEN*ADDR_W-1:0]   addr,
    output logic [TRAIN_LEN-1:0]          addr_vld,
    output logic                          busy,
    output logic                          reach_dest,
    output logic                          err,
    output logic [ADDR_W:0]               step_cnt
);

    // Timer only ever counts one phase at a time, so it is sized for the longer one.
    localparam int TMR_MAX = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int ADDR_MAX = (1 << ADDR_W) - 1;

    localparam logic [TMR_W-1:0]  HOLD_LAST  = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST   = TMR_W'(GAP_CYC - 1);
    // One bit wider than drop_sel so the limit itself is representable.
    localparam logic [DROP_W:0]   DROP_LIMIT = (DROP_W + 1)'(NUM_DROP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACT,
        S_GAP,
        S_STEP,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ADDR_W-1:0]   head_q, head_d;
    logic                dir_q, dir_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [DROP_W-1:0]   sel_q, sel_d;
    logic                use_stored_q, use_stored_d;
    logic [ADDR_W:0]     step_cnt_q, step_cnt_d;
    logic                act_q, act_d;
    logic                busy_q, busy_d;
    logic                reach_q, reach_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   pos_q [NUM_DROP];
    logic [ADDR_W-1:0]   pos_d [NUM_DROP];

    logic [ADDR_W-1:0]   load_head;
    logic [ADDR_W-1:0]   step_head;
    logic                sel_bad;

    // Next-state, datapath and registered-output decode.
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        head_d       = head_q;
        dir_d        = dir_q;
        dest_d       = dest_q;
        src_d        = src_q;
        sel_d        = sel_q;
        use_stored_d = use_stored_q;
        step_cnt_d   = step_cnt_q;
        pos_d        = pos_q;
        err_d        = 1'b0;

        sel_bad   = ({1'b0, drop_sel} >= DROP_LIMIT);
        load_head = use_stored_q ? pos_q[sel_q] : src_q;
        step_head = dir_q ? (head_q + 1'b1) : (head_q - 1'b1);

        if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (sel_bad) begin
                            err_d = 1'b1;
                        end else begin
                            // Request is captured here so later input changes cannot leak in.
                            dest_d       = dest;
                            src_d        = src;
                            sel_d        = drop_sel;
                            use_stored_d = use_stored;
                            state_d      = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    head_d     = load_head;
                    dir_d      = (dest_q >= load_head);
                    step_cnt_d = '0;
                    timer_d    = '0;
                    state_d    = (load_head == dest_q) ? S_DONE : S_ACT;
                end
                S_ACT: begin
                    if (timer_q == HOLD_LAST) begin
                        timer_d = '0;
                        state_d = S_GAP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        timer_d = '0;
                        state_d = S_STEP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_STEP: begin
                    head_d     = step_head;
                    step_cnt_d = step_cnt_q + 1'b1;
                    timer_d    = '0;
                    state_d    = (step_head == dest_q) ? S_DONE : S_ACT;
                end
                S_DONE: begin
                    pos_d[sel_q] = head_q;
                    state_d      = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state and registered, so they
        // change only on a clock edge and never glitch.
        act_d   = (state_d == S_ACT);
        busy_d  = (state_d inside {S_LOAD, S_ACT, S_GAP, S_STEP});
        reach_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            head_q       <= '0;
            dir_q        <= 1'b0;
            dest_q       <= '0;
            src_q        <= '0;
            sel_q        <= '0;
            use_stored_q <= 1'b0;
            step_cnt_q   <= '0;
            act_q        <= 1'b0;
            busy_q       <= 1'b0;
            reach_q      <= 1'b0;
            err_q        <= 1'b0;
            // NOTE: the position table is small and must read 0 after reset,
            // so it is built from resettable flops rather than a RAM.
            for (int i = 0; i < NUM_DROP; i++) begin
                pos_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            head_q       <= head_d;
            dir_q        <= dir_d;
            dest_q       <= dest_d;
            src_q        <= src_d;
            sel_q        <= sel_d;
            use_stored_q <= use_stored_d;
            step_cnt_q   <= step_cnt_d;
            act_q        <= act_d;
            busy_q       <= busy_d;
            reach_q      <= reach_d;
            err_q        <= err_d;
            pos_q        <= pos_d;
        end
    end

    // Train addresses trail the head; slots that fall off either end of the
    // electrode array read as invalid/zero instead of wrapping.
    always_comb begin
        int   slot;
        logic show;
        addr     = '0;
        addr_vld = '0;
        slot     = 0;
        show     = (state_q inside {S_ACT, S_GAP, S_STEP, S_DONE});
        for (int k = 0; k < TRAIN_LEN; k++) begin
            // Computed in a wide signed domain so an out-of-range slot is
            // detected rather than folded back into the array.
            slot = dir_q ? (int'(head_q) - k) : (int'(head_q) + k);
            if (show && (slot >= 0) && (slot <= ADDR_MAX)) begin
                addr[k*ADDR_W +: ADDR_W] = ADDR_W'(slot);
                addr_vld[k]              = 1'b1;
            end
        end
    end

    assign act        = act_q;
    assign busy       = busy_q;
    assign reach_dest = reach_q;
    assign err        = err_q;
    assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_dmfb_train_move_sequencer.sv
// Testbench for dmfb_train_move_sequencer.
// A schedule-level model predicts every output from the number of enabled
// cycles elapsed since a move was accepted; a compare process checks the
// main DUT against it every cycle, and directed moves add literal checks.

module tb_dmfb_train_move_sequencer;

    localparam int ADDR_W   = 4;
    localparam int TRAIN_LEN = 4;
    localparam int NUM_DROP = 2;
    localparam int HOLD     = 1000;
    localparam int GAP      = 100;
    localparam int P        = HOLD + GAP + 1;
    localparam int MAX_ADDR = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        start;
    logic        drop_sel;
    logic        use_stored;
    logic [3:0]  src;
    logic [3:0]  dest;
    logic        act;
    logic [15:0] addr;
    logic [3:0]  addr_vld;
    logic        busy;
    logic        reach_dest;
    logic        err;
    logic [4:0]  step_cnt;

    // Second instance with three droplets so that an index of 3 is expressible.
    logic        start3;
    logic [1:0]  drop_sel3;
    logic        act3;
    logic [15:0] addr3;
    logic [3:0]  addr_vld3;
    logic        busy3;
    logic        reach3;
    logic        err3;
    logic [4:0]  step_cnt3;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dmfb_train_move_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .drop_sel   (drop_sel),
        .use_stored (use_stored),
        .src        (src),
        .dest       (dest),
        .act        (act),
        .addr       (addr),
        .addr_vld   (addr_vld),
        .busy       (busy),
        .reach_dest (reach_dest),
        .err        (err),
        .step_cnt   (step_cnt)
    );

    dmfb_train_move_sequencer #(
        .NUM_DROP (3),
        .HOLD_CYC (2),
        .GAP_CYC  (1)
    ) dut3 (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start3),
        .drop_sel   (drop_sel3),
        .use_stored (1'b0),
        .src        (src),
        .dest       (dest),
        .act        (act3),
        .addr       (addr3),
        .addr_vld   (addr_vld3),
        .busy       (busy3),
        .reach_dest (reach3),
        .err        (err3),
        .step_cnt   (step_cnt3)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // ---------------- schedule model ----------------
    bit m_active;
    int m_e;       // enabled edges since the accepting edge (1 = first cycle after accept)
    int m_h0;
    bit m_dir;
    int m_n;       // steps this move needs
    int m_dest;
    int m_sel;
    int m_last;    // step count left over from the previous move
    bit m_err;
    int m_pos [NUM_DROP];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0;
            m_e      = 0;
            m_last   = 0;
            m_err    = 1'b0;
            for (int i = 0; i < NUM_DROP; i++) m_pos[i] = 0;
        end else begin
            m_err = 1'b0;
            if (enable) begin
                if (m_active) begin
                    m_e++;
                    if (m_e > 2 + m_n * P) begin
                        m_active     = 1'b0;
                        m_last       = m_n;
                        m_pos[m_sel] = m_dest;
                    end
                end else if (start) begin
                    m_sel = int'(drop_sel);
                    if (m_sel >= NUM_DROP) begin
                        m_err = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_e      = 1;
                        m_h0     = use_stored ? m_pos[m_sel] : int'(src);
                        m_dest   = int'(dest);
                        m_dir    = (m_dest >= m_h0);
                        m_n      = m_dir ? (m_dest - m_h0) : (m_h0 - m_dest);
                    end
                end
            end
        end
    end

    // Expected outputs: cycle 1 loads, then N periods of HOLD act + GAP idle + 1 step,
    // then one done cycle.
    function automatic logic [63:0] model_outputs();
        logic        e_act, e_busy, e_reach;
        logic [4:0]  e_step;
        logic [15:0] e_addr;
        logic [3:0]  e_vld;
        int          head, j, r, a;
        bit          show;
        e_act = 1'b0; e_busy = 1'b0; e_reach = 1'b0;
        e_step = 5'(m_last); e_addr = '0; e_vld = '0;
        head = 0; show = 1'b0;
        if (m_active) begin
            if (m_e == 1) begin
                e_busy = 1'b1;
            end else if (m_e <= 1 + m_n * P) begin
                j      = (m_e - 2) / P;
                r      = (m_e - 2) % P;
                e_busy = 1'b1;
                e_act  = (r < HOLD);
                e_step = 5'(j);
                head   = m_dir ? (m_h0 + j) : (m_h0 - j);
                show   = 1'b1;
            end else begin
                e_reach = 1'b1;
                e_step  = 5'(m_n);
                head    = m_dest;
                show    = 1'b1;
            end
        end
        if (show) begin
            for (int k = 0; k < TRAIN_LEN; k++) begin
                a = m_dir ? (head - k) : (head + k);
                if (a >= 0 && a <= MAX_ADDR) begin
                    e_addr[k*ADDR_W +: ADDR_W] = 4'(a);
                    e_vld[k] = 1'b1;
                end
            end
        end
        return {35'b0, e_act, e_busy, e_reach, m_err, e_step, e_addr, e_vld};
    endfunction

    // Per-cycle comparison of the main DUT against the model.
    always @(posedge clock) begin
        #1;
        check("cycle", {35'b0, act, busy, reach_dest, err, step_cnt, addr, addr_vld}, model_outputs());
    end

    // ---------------- stimulus ----------------
    task automatic run_move(input bit sel, input bit us, input logic [3:0] s, input logic [3:0] d,
                            input int freeze_at, input int poke_at,
                            output int lat, output int act_cnt,
                            output logic [15:0] a0, output logic [3:0] v0);
        bit seen_act;
        int n;
        seen_act = 1'b0; lat = -1; act_cnt = 0; a0 = '0; v0 = '0;
        @(negedge clock);
        drop_sel = sel; use_stored = us; src = s; dest = d; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (n < 20000) begin
            @(posedge clock);
            #1;
            n++;
            if (act) begin
                act_cnt++;
                if (!seen_act) begin
                    seen_act = 1'b1; a0 = addr; v0 = addr_vld;
                end
            end
            if (n == freeze_at)      enable = 1'b0;
            if (n == freeze_at + 50) enable = 1'b1;
            if (n == poke_at) begin
                start = 1'b1; drop_sel = 1'b1; use_stored = 1'b1; src = 4'd9; dest = 4'd14;
            end
            if (n == poke_at + 1) start = 1'b0;
            if (reach_dest) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) check("move_timeout", reach_dest, 1'b1);
        @(negedge clock);
    endtask

    int          lat, act_cnt;
    logic [15:0] a0;
    logic [3:0]  v0;

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; drop_sel = 1'b0; use_stored = 1'b0;
        src = 4'd0; dest = 4'd0; start3 = 1'b0; drop_sel3 = 2'd0;
        repeat (3) @(negedge clock);
        check("reset_act",  act, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_step", step_cnt, 5'd0);
        check("reset_addr", {addr, addr_vld}, 20'h0);
        reset = 1'b0;

        // Out-of-range droplet index is rejected with a one-cycle err.
        @(negedge clock); drop_sel3 = 2'd3; start3 = 1'b1;
        @(negedge clock); start3 = 1'b0;
        check("err_pulse", err3, 1'b1);
        check("err_busy", busy3, 1'b0);
        @(negedge clock);
        check("err_clear", err3, 1'b0);
        check("err_busy_after", busy3, 1'b0);
        @(negedge clock); drop_sel3 = 2'd2; start3 = 1'b1;
        @(negedge clock); start3 = 1'b0;
        check("accept_busy", busy3, 1'b1);
        check("accept_err", err3, 1'b0);
        repeat (4) @(negedge clock);

        // Droplet 1: 0 -> 7, then continue from its stored position to 3.
        run_move(1'b1, 1'b0, 4'd0, 4'd7, -100, -100, lat, act_cnt, a0, v0);
        check("d1_lat", lat, 1 + 7 * 1101 + 1);
        check("d1_first_addr", {a0, v0}, {16'h0000, 4'b0001});
        run_move(1'b1, 1'b1, 4'd15, 4'd3, -100, -100, lat, act_cnt, a0, v0);
        check("stored_lat", lat, 1 + 4 * 1101 + 1);
        check("stored_first_addr", {a0, v0}, {16'hA987, 4'b1111});
        check("stored_steps", step_cnt, 5'd4);
        run_move(1'b1, 1'b1, 4'd0, 4'd3, -100, -100, lat, act_cnt, a0, v0);
        check("pos1_is_3_lat", lat, 2);
        check("pos1_is_3_act", act_cnt, 0);
        run_move(1'b0, 1'b1, 4'd5, 4'd0, -100, -100, lat, act_cnt, a0, v0);
        check("pos0_is_0_lat", lat, 2);

        // Forward move 2 -> 5.
        run_move(1'b0, 1'b0, 4'd2, 4'd5, -100, -100, lat, act_cnt, a0, v0);
        check("fwd_lat", lat, 1 + 3 * 1101 + 1);
        check("fwd_act_cycles", act_cnt, 3000);
        check("fwd_first_addr", {a0, v0}, {16'h0012, 4'b0111});
        check("fwd_steps", step_cnt, 5'd3);

        // Reverse move 12 -> 9.
        run_move(1'b0, 1'b0, 4'd12, 4'd9, -100, -100, lat, act_cnt, a0, v0);
        check("rev_lat", lat, 1 + 3 * 1101 + 1);
        check("rev_first_addr", {a0, v0}, {16'hFEDC, 4'b1111});

        // Zero-length move.
        run_move(1'b0, 1'b0, 4'd6, 4'd6, -100, -100, lat, act_cnt, a0, v0);
        check("same_lat", lat, 2);
        check("same_act", act_cnt, 0);

        // Enable dropped for 50 cycles mid-ACT; start with new inputs issued in GAP.
        run_move(1'b0, 1'b0, 4'd0, 4'd1, 300, 1100, lat, act_cnt, a0, v0);
        check("freeze_lat", lat, 1 + 1101 + 1 + 50);
        check("freeze_act_cycles", act_cnt, 1000 + 50);
        check("freeze_steps", step_cnt, 5'd1);
        repeat (3) @(negedge clock);
        check("ignored_start_busy", busy, 1'b0);

        // Reset in the second GAP of a move.
        @(negedge clock);
        drop_sel = 1'b0; use_stored = 1'b0; src = 4'd2; dest = 4'd5; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (2107) @(posedge clock);
        #1;
        check("pre_reset_busy", busy, 1'b1);
        check("pre_reset_step", step_cnt, 5'd1);
        #2 reset = 1'b1;
        #1;
        check("gap_reset_act",  act, 1'b0);
        check("gap_reset_busy", busy, 1'b0);
        check("gap_reset_step", step_cnt, 5'd0);
        @(negedge clock); reset = 1'b0;

        // Reset in ACT drops act immediately.
        @(negedge clock);
        src = 4'd3; dest = 4'd8; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        check("pre_reset_act", act, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("act_reset_act", act, 1'b0);
        @(negedge clock); reset = 1'b0;

        // After reset all stored positions are 0 and IDLE accepts a new move.
        run_move(1'b1, 1'b1, 4'd9, 4'd2, -100, -100, lat, act_cnt, a0, v0);
        check("post_reset_lat", lat, 1 + 2 * 1101 + 1);
        check("post_reset_first_addr", {a0, v0}, {16'h0000, 4'b0001});

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
